// File: rtl/fpga_reset_conditioner.sv
// fpga_reset_conditioner
// Board-level reset sequencer in front of heepstor_top. Produces a glitch-free
// active-low system reset that releases synchronously to clk_i, only after the
// clock wizard has reported a stable lock for DEBOUNCE_CYCLES cycles and a
// further HOLD_CYCLES cycles have elapsed. It also keeps saturating debug
// counters of lock losses and software reset requests seen while running.
//
// Ports:
//   clk_i           clock-wizard output clock
//   rst_i           board reset button, async, active-high (clears every flop)
//   locked_i        clock-wizard lock, asynchronous to clk_i
//   sw_rst_req_i    single-cycle software reset request, synchronous to clk_i
//   rst_no          registered active-low reset to heepstor_top
//   state_o         current FSM state (encoding in the table below)
//   lock_loss_cnt_o saturating count of lock losses seen in RUN
//   sw_rst_cnt_o    saturating count of accepted software requests
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RESET     | 0: waiting for the release synchronizer to pass rst_i low
// WAIT_LOCK | 1: debouncing locked_s; any low sample restarts the count
// HOLD      | 2: lock qualified, stretching reset for HOLD_CYCLES edges
// RUN       | 3: rst_no released; lock loss or sw request leaves RUN

module fpga_reset_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int HOLD_CYCLES     = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       sw_rst_req_i,
  output logic       rst_no,
  output logic [1:0] state_o,
  output logic [3:0] lock_loss_cnt_o,
  output logic [3:0] sw_rst_cnt_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RESET     = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_HOLD      = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] rel_sync;
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   rel_s;
  logic                   locked_s;
  logic [DEB_W-1:0]       deb_cnt;
  logic [HOLD_W-1:0]      hold_cnt;

  assign rel_s    = rel_sync[SYNC_STAGES-1];
  assign locked_s = lock_sync[SYNC_STAGES-1];
  assign state_o  = state;

  // Both chains clear on rst_i so a lock that was high before reset still has
  // to travel the full synchronizer depth again.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rel_sync  <= '0;
      lock_sync <= '0;
    end else begin
      rel_sync  <= {rel_sync[SYNC_STAGES-2:0], 1'b1};
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], locked_i};
    end
  end

  // rst_no defaults low every edge and is only driven high on the branches
  // whose next state is RUN, so it is a pure function of the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state           <= S_RESET;
      rst_no          <= 1'b0;
      deb_cnt         <= '0;
      hold_cnt        <= '0;
      lock_loss_cnt_o <= '0;
      sw_rst_cnt_o    <= '0;
    end else begin
      rst_no <= 1'b0;
      case (state)
        S_RESET: begin
          if (rel_s) begin
            state   <= S_WAIT_LOCK;
            deb_cnt <= '0;
          end
        end
        S_WAIT_LOCK: begin
          if (!locked_s) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= S_HOLD;
            deb_cnt  <= '0;
            hold_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end
        S_HOLD: begin
          if (!locked_s) begin
            state   <= S_WAIT_LOCK;
            deb_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= S_RUN;
            rst_no   <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          // Lock loss has priority over a coincident software request.
          if (!locked_s) begin
            state   <= S_WAIT_LOCK;
            deb_cnt <= '0;
            if (lock_loss_cnt_o != 4'hF) lock_loss_cnt_o <= lock_loss_cnt_o + 4'd1;
          end else if (sw_rst_req_i) begin
            state    <= S_HOLD;
            hold_cnt <= '0;
            if (sw_rst_cnt_o != 4'hF) sw_rst_cnt_o <= sw_rst_cnt_o + 4'd1;
          end else begin
            rst_no <= 1'b1;
          end
        end
        default: begin
          state <= S_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_reset_conditioner.sv
module tb_fpga_reset_conditioner;

  localparam int SS = 2;
  localparam int DB = 4;
  localparam int HC = 8;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       locked_i = 1'b0;
  logic       sw_rst_req_i = 1'b0;
  logic       rst_no;
  logic [1:0] state_o;
  logic [3:0] lock_loss_cnt_o;
  logic [3:0] sw_rst_cnt_o;

  fpga_reset_conditioner #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .locked_i       (locked_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .rst_no         (rst_no),
    .state_o        (state_o),
    .lock_loss_cnt_o(lock_loss_cnt_o),
    .sw_rst_cnt_o   (sw_rst_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         cyc;
    logic       rst_n;
    logic [1:0] st;
    logic [3:0] ll;
    logic [3:0] sw;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [10:0] prev;
  logic [10:0] mon_cur;
  exp_t        mon_e;
  logic [3:0]  ll_m = 4'd0;
  logic [3:0]  sw_m = 4'd0;

  always @(posedge clk_i) cyc++;

  // Monitor: every change of the observable outputs must match the next
  // expected event, including the edge number at which it happens.
  always @(negedge clk_i) begin
    if (mon_en) begin
      mon_cur = {rst_no, state_o, lock_loss_cnt_o, sw_rst_cnt_o};
      if (mon_cur !== prev) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change edge=%0d got rst_no=%b st=%0d ll=%0d sw=%0d",
                   cyc, mon_cur[10], mon_cur[9:8], mon_cur[7:4], mon_cur[3:0]);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.cyc != cyc || mon_cur !== {mon_e.rst_n, mon_e.st, mon_e.ll, mon_e.sw}) begin
            errors++;
            $display("FAIL event edge=%0d got rst_no=%b st=%0d ll=%0d sw=%0d ; want edge=%0d rst_no=%b st=%0d ll=%0d sw=%0d",
                     cyc, mon_cur[10], mon_cur[9:8], mon_cur[7:4], mon_cur[3:0],
                     mon_e.cyc, mon_e.rst_n, mon_e.st, mon_e.ll, mon_e.sw);
          end
        end
        prev = mon_cur;
      end
    end
  end

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? 4'hF : v + 4'd1;
  endfunction

  function automatic void push(input int c, input logic r, input logic [1:0] s,
                               input logic [3:0] l, input logic [3:0] w);
    exp_t e;
    e.cyc = c; e.rst_n = r; e.st = s; e.ll = l; e.sw = w;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drain(input string name, input int budget, input int quiet);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout pending=%0d want=0", name, sb.size());
      sb.delete();
    end
    ticks(quiet);
  endtask

  task automatic check_reset(input string name);
    checks++;
    if ({rst_no, state_o, lock_loss_cnt_o, sw_rst_cnt_o} !== 11'd0) begin
      errors++;
      $display("FAIL %s got rst_no=%b st=%0d ll=%0d sw=%0d want all 0",
               name, rst_no, state_o, lock_loss_cnt_o, sw_rst_cnt_o);
    end
  endtask

  // Called just after an edge; the async change is seen at the following negedge.
  task automatic assert_rst(input string name);
    push(cyc, 1'b0, 2'd0, 4'd0, 4'd0);
    rst_i = 1'b1;
    #1;
    check_reset(name);
    ll_m = 4'd0;
    sw_m = 4'd0;
  endtask

  task automatic release_rst(output int r);
    tick();
    rst_i = 1'b0;
    r = cyc;
  endtask

  task automatic restore_lock();
    int c;
    locked_i = 1'b1;
    c = cyc;
    push(c + SS + DB, 1'b0, 2'd2, ll_m, sw_m);
    push(c + SS + DB + HC, 1'b1, 2'd3, ll_m, sw_m);
  endtask

  task automatic lock_loss(input bit with_sw);
    int b;
    tick();
    locked_i = 1'b0;
    b = cyc;
    ll_m = sat_inc(ll_m);
    push(b + SS + 1, 1'b0, 2'd1, ll_m, sw_m);
    if (with_sw) begin
      ticks(2);
      sw_rst_req_i = 1'b1;
      tick();
      sw_rst_req_i = 1'b0;
      ticks(2);
    end else begin
      ticks(5);
    end
    restore_lock();
    drain("lock_loss", 60, 3);
  endtask

  initial begin
    int r;
    int k;
    int b;
    locked_i = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check_reset("reset_state");
    prev = 11'd0;
    mon_en = 1'b1;

    // Power-up: state 1/2/3 at edges 3/7/15 after release.
    ticks(2);
    release_rst(r);
    push(r + 3, 1'b0, 2'd1, 4'd0, 4'd0);
    push(r + 7, 1'b0, 2'd2, 4'd0, 4'd0);
    push(r + 15, 1'b1, 2'd3, 4'd0, 4'd0);
    drain("power_up", 40, 3);

    // Software request in RUN, then a second pulse while in HOLD is ignored.
    tick();
    sw_rst_req_i = 1'b1;
    k = cyc + 1;
    sw_m = sat_inc(sw_m);
    push(k, 1'b0, 2'd2, ll_m, sw_m);
    push(k + HC, 1'b1, 2'd3, ll_m, sw_m);
    tick();
    sw_rst_req_i = 1'b0;
    tick();
    sw_rst_req_i = 1'b1;
    tick();
    sw_rst_req_i = 1'b0;
    drain("sw_reset", 40, 3);

    // Software request, then lock drops during HOLD: back to WAIT_LOCK, no count.
    tick();
    sw_rst_req_i = 1'b1;
    k = cyc + 1;
    sw_m = sat_inc(sw_m);
    push(k, 1'b0, 2'd2, ll_m, sw_m);
    tick();
    sw_rst_req_i = 1'b0;
    locked_i = 1'b0;
    push(k + SS + 1, 1'b0, 2'd1, ll_m, sw_m);
    ticks(5);
    restore_lock();
    drain("hold_lock_drop", 60, 3);

    lock_loss(1'b0);
    lock_loss(1'b1);

    // Third lock loss, then reset asserted while in HOLD with counters 3/2.
    tick();
    locked_i = 1'b0;
    b = cyc;
    ll_m = sat_inc(ll_m);
    push(b + SS + 1, 1'b0, 2'd1, ll_m, sw_m);
    ticks(5);
    locked_i = 1'b1;
    push(cyc + SS + DB, 1'b0, 2'd2, ll_m, sw_m);
    drain("to_hold", 40, 0);
    assert_rst("mid_reset");
    ticks(2);
    release_rst(r);
    push(r + 3, 1'b0, 2'd1, 4'd0, 4'd0);
    push(r + 7, 1'b0, 2'd2, 4'd0, 4'd0);
    push(r + 15, 1'b1, 2'd3, 4'd0, 4'd0);
    drain("re_power_up", 40, 3);

    // Seventeen lock losses saturate the counter at 15.
    for (int i = 0; i < 17; i++) lock_loss(1'b0);

    // Late lock with a one-cycle glitch restarting the debounce.
    tick();
    locked_i = 1'b0;
    assert_rst("late_lock_reset");
    ticks(2);
    release_rst(r);
    push(r + 3, 1'b0, 2'd1, 4'd0, 4'd0);
    ticks(10);
    locked_i = 1'b1;
    ticks(2);
    locked_i = 1'b0;
    tick();
    restore_lock();
    drain("late_lock", 60, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
